// File: rtl/vec_spi_rx.sv
// -----------------------------------------------------------------------------
// vec_spi_rx
// SPI slave receiver for the raycaster view vectors (player position, facing,
// camera plane). It oversamples the SPI pins in the clk domain and accepts only
// frames that are exactly FRAME_BITS long. The last good frame is held in a
// pending buffer and is committed to o_vectors on the next vblank rising edge,
// so the core never sees the vectors change in the middle of a frame.
//
// Optional feature: define VEC_SPI_RX_ERRCNT_EN to add a saturating 8-bit
// frame-error counter (o_err_count) with a clear input (i_err_clr).
//
// Ports:
//   clk          design clock
//   reset        asynchronous, active-high reset
//   i_ss_n       SPI chip select, active low (async to clk)
//   i_sclk       SPI clock (async); MOSI is sampled on its rising edge
//   i_mosi       SPI data, MSB of the frame first
//   i_vblank     vertical blank, clk domain
//   o_vectors    committed vectors, component 0 in the MSBs
//   o_load       one-cycle pulse when o_vectors updates
//   o_pending    a good frame is waiting for vblank
//   o_frame_err  one-cycle pulse on a malformed frame
//   i_err_clr    (ERRCNT only) clear the error counter, wins over increment
//   o_err_count  (ERRCNT only) saturating frame-error count
// -----------------------------------------------------------------------------
module vec_spi_rx #(
    parameter int VEC_W       = 16,
    parameter int NVEC        = 6,
    parameter int SYNC_STAGES = 2,
    parameter logic [NVEC*VEC_W-1:0] INIT_VEC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_ss_n,
    input  logic                    i_sclk,
    input  logic                    i_mosi,
    input  logic                    i_vblank,
    output logic [NVEC*VEC_W-1:0]   o_vectors,
    output logic                    o_load,
    output logic                    o_pending,
    output logic                    o_frame_err
`ifdef VEC_SPI_RX_ERRCNT_EN
    ,
    input  logic                    i_err_clr,
    output logic [7:0]              o_err_count
`endif
);

    localparam int FRAME_BITS = NVEC * VEC_W;
    localparam int CW         = $clog2(FRAME_BITS) + 1;
    localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN, CHECK} state_t;

    // Synchroniser chains: index 0 is the newest sample, SYNC_STAGES-1 the
    // last synchroniser stage, and SYNC_STAGES a history flop for edges.
    logic [SYNC_STAGES:0]   r_ss_sync;
    logic [SYNC_STAGES:0]   r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    // Fill tracker: edges are only trusted once every flop in the chain holds a
    // real pin sample. Without it the reset presets look like an ss_n fall
    // when the pin is already low, and a frame in flight would be captured.
    logic [SYNC_STAGES:0]   r_sync_vld;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [FRAME_BITS-1:0]  r_shreg;
    logic [FRAME_BITS-1:0]  r_pend;
    logic                   r_vb_d;

    logic w_sync_ok, w_ss_rise, w_ss_fall, w_sclk_rise, w_mosi, w_vb_rise;

    assign w_sync_ok   = &r_sync_vld;
    assign w_ss_rise   = w_sync_ok &  r_ss_sync[SYNC_STAGES-1] & ~r_ss_sync[SYNC_STAGES];
    assign w_ss_fall   = w_sync_ok & ~r_ss_sync[SYNC_STAGES-1] &  r_ss_sync[SYNC_STAGES];
    assign w_sclk_rise = w_sync_ok &  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
    // MOSI taken at the same depth as the sclk stage that flags the rise.
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_vb_rise   = i_vblank & ~r_vb_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sync_vld  <= '0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-1:0], i_ss_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-1:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_pend      <= '0;
            r_vb_d      <= 1'b1;
            o_vectors   <= INIT_VEC;
            o_load      <= 1'b0;
            o_pending   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_load      <= 1'b0;
            o_frame_err <= 1'b0;
            r_vb_d      <= i_vblank;

            // Commit reads r_pend before any same-cycle CHECK write; the CHECK
            // assignment to o_pending below then overrides the clear here.
            if (w_vb_rise && o_pending) begin
                o_vectors <= r_pend;
                o_load    <= 1'b1;
                o_pending <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_ss_rise) begin
                        r_state <= CHECK;
                    end else if (w_sclk_rise) begin
                        if (r_cnt == FULL) begin
                            r_state <= OVERRUN;
                        end else begin
                            r_shreg <= {r_shreg[FRAME_BITS-2:0], w_mosi};
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                OVERRUN: begin
                    if (w_ss_rise) begin
                        o_frame_err <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                CHECK: begin
                    if (r_cnt == FULL) begin
                        r_pend    <= r_shreg;
                        o_pending <= 1'b1;
                    end else begin
                        o_frame_err <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VEC_SPI_RX_ERRCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_err_count <= '0;
        end else if (i_err_clr) begin
            o_err_count <= '0;
        end else if (o_frame_err && (o_err_count != 8'hFF)) begin
            o_err_count <= o_err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_spi_rx.sv
module tb_vec_spi_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_ss_n = 1'b1;
    logic        i_sclk = 1'b0;
    logic        i_mosi = 1'b0;
    logic        i_vblank = 1'b0;
    logic [95:0] o_vectors;
    logic        o_load, o_pending, o_frame_err;
`ifdef VEC_SPI_RX_ERRCNT_EN
    logic        i_err_clr = 1'b0;
    logic [7:0]  o_err_count;
`endif

    vec_spi_rx dut (
        .clk        (clk),
        .reset      (reset),
        .i_ss_n     (i_ss_n),
        .i_sclk     (i_sclk),
        .i_mosi     (i_mosi),
        .i_vblank   (i_vblank),
        .o_vectors  (o_vectors),
        .o_load     (o_load),
        .o_pending  (o_pending),
        .o_frame_err(o_frame_err)
`ifdef VEC_SPI_RX_ERRCNT_EN
        ,
        .i_err_clr  (i_err_clr),
        .o_err_count(o_err_count)
`endif
    );

    always #5 clk = ~clk;

    // Running totals of output pulses, sampled away from the active edge.
    int tot_err = 0;
    int tot_load = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (o_frame_err) tot_err++;
            if (o_load) tot_load++;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // SPI at clk/8: each sclk phase lasts 4 clk.
    task automatic ss_low();
        i_ss_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input int n, input logic [95:0] data);
        for (int i = 0; i < n; i++) begin
            i_sclk = 1'b0;
            i_mosi = (i < 96) ? data[95-i] : 1'b0;
            repeat (4) @(negedge clk);
            i_sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        i_sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        i_ss_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic vblank_pulse();
        i_vblank = 1'b1;
        repeat (3) @(negedge clk);
        i_vblank = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int          nbits;    // -1: no frame, 0: empty ss_n window
        logic [95:0] data;
        bit          vb;
        int          exp_err;
        bit          exp_pend;
        int          exp_load;
        logic [95:0] exp_vec;
    } vec_t;

    localparam logic [95:0] D1 = 96'h0123_4567_89AB_CDEF_0011_2233;
    localparam logic [95:0] D2 = 96'hFEDC_BA98_7654_3210_FFEE_DDCC;
    localparam logic [95:0] DA = 96'hA5A5_5A5A_1234_8001_7FFF_C3C3;
    localparam logic [95:0] DB = 96'h0F0F_F0F0_BEEF_CAFE_0001_8000;

    vec_t tbl[10];

    initial begin
        int e0, l0;
        tbl[0] = '{96, D1, 1'b0, 0, 1'b1, 0, 96'h0};
        tbl[1] = '{-1, D1, 1'b1, 0, 1'b0, 1, D1};
        tbl[2] = '{95, D2, 1'b1, 1, 1'b0, 0, D1};
        tbl[3] = '{97, D2, 1'b0, 1, 1'b0, 0, D1};
        tbl[4] = '{96, DA, 1'b0, 0, 1'b1, 0, D1};
        tbl[5] = '{97, D2, 1'b1, 1, 1'b0, 1, DA};
        tbl[6] = '{96, D2, 1'b0, 0, 1'b1, 0, DA};
        tbl[7] = '{96, DB, 1'b1, 0, 1'b0, 1, DB};
        tbl[8] = '{0,  D1, 1'b1, 1, 1'b0, 0, DB};
        tbl[9] = '{-1, D1, 1'b1, 0, 1'b0, 0, DB};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_vectors", o_vectors, 96'h0);
        chk("rst_load", 96'(o_load), 96'h0);
        chk("rst_pending", 96'(o_pending), 96'h0);
        chk("rst_frame_err", 96'(o_frame_err), 96'h0);

        for (int r = 0; r < 10; r++) begin
            e0 = tot_err;
            l0 = tot_load;
            if (tbl[r].nbits >= 0) begin
                ss_low();
                send_bits(tbl[r].nbits, tbl[r].data);
                ss_high();
            end
            if (tbl[r].vb) vblank_pulse();
            chk($sformatf("rec%0d_err", r), 96'(tot_err - e0), 96'(tbl[r].exp_err));
            chk($sformatf("rec%0d_pend", r), 96'(o_pending), 96'(tbl[r].exp_pend));
            chk($sformatf("rec%0d_load", r), 96'(tot_load - l0), 96'(tbl[r].exp_load));
            chk($sformatf("rec%0d_vec", r), o_vectors, tbl[r].exp_vec);
        end

        // CHECK of frame B lands on the same cycle as the vblank edge that
        // commits pending frame A: A loads, B stays pending.
        ss_low(); send_bits(96, DA); ss_high();
        chk("sim_a_pend", 96'(o_pending), 96'h1);
        ss_low(); send_bits(96, DB);
        i_ss_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("sim_pre_load", 96'(o_load), 96'h0);
        i_vblank = 1'b1;
        @(negedge clk);
        chk("sim_vec_a", o_vectors, DA);
        chk("sim_load", 96'(o_load), 96'h1);
        chk("sim_b_pend", 96'(o_pending), 96'h1);
        repeat (2) @(negedge clk);
        i_vblank = 1'b0;
        repeat (4) @(negedge clk);
        vblank_pulse();
        chk("sim_vec_b", o_vectors, DB);
        chk("sim_b_done", 96'(o_pending), 96'h0);

        // Reset in the middle of a frame; the tail must not be captured.
        e0 = tot_err;
        l0 = tot_load;
        ss_low();
        send_bits(40, D1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_vec", o_vectors, 96'h0);
        reset = 1'b0;
        send_bits(56, D1 << 40);
        ss_high();
        vblank_pulse();
        chk("mid_err", 96'(tot_err - e0), 96'h0);
        chk("mid_pend", 96'(o_pending), 96'h0);
        chk("mid_load", 96'(tot_load - l0), 96'h0);
        chk("mid_vec", o_vectors, 96'h0);

        // Receiver is usable again after the reset.
        ss_low(); send_bits(96, D2); ss_high(); vblank_pulse();
        chk("post_rst_vec", o_vectors, D2);

`ifdef VEC_SPI_RX_ERRCNT_EN
        begin
            bit seen;
            for (int k = 0; k < 300; k++) begin
                ss_low(); send_bits(1, D1); ss_high();
            end
            chk("errcnt_sat", 96'(o_err_count), 96'd255);
            ss_low(); send_bits(1, D1);
            i_ss_n = 1'b1;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (o_frame_err) begin
                    seen = 1'b1;
                    i_err_clr = 1'b1;
                    @(negedge clk);
                    i_err_clr = 1'b0;
                end
            end
            chk("errclr_err_seen", 96'(seen), 96'h1);
            chk("errclr_count", 96'(o_err_count), 96'd0);
            repeat (8) @(negedge clk);
            ss_low(); send_bits(1, D1); ss_high();
            chk("errcnt_after_clr", 96'(o_err_count), 96'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_spi_rx.md
Name: vec_spi_rx

Overview:
- SPI slave receiver for view vectors (player pos, facing, camera plane), driven from LA pins i_vec_csb/i_vec_sclk/i_vec_mosi.
- Sits directly upstream of the raycaster core; oversamples the SPI lines in the clk domain.
- Accepts only exact-length frames, holds the last good frame in a pending buffer, and commits it to the core on the next vblank rising edge so vectors never change mid-frame.

Parameters:
- VEC_W, 16, bits per vector component.
- NVEC, 6, number of components; FRAME_BITS = NVEC*VEC_W (96).
- SYNC_STAGES, 2, flops per input synchroniser (min 2).
- INIT_VEC, 96'h0, value of o_vectors after reset.

Ports:
- clk  in  1  design clock.
- reset  in  1  asynchronous, active-high reset.
- i_ss_n  in  1  SPI chip select, active low, async to clk.
- i_sclk  in  1  SPI clock, async; MOSI sampled on its rising edge.
- i_mosi  in  1  SPI data, MSB of frame first.
- i_vblank  in  1  vertical blank from VGA timing, clk domain.
- o_vectors  out  FRAME_BITS  committed vectors; component 0 in the MSBs.
- o_load  out  1  one-cycle pulse when o_vectors updates.
- o_pending  out  1  a good frame is waiting for vblank.
- o_frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset (async assert, sync release by clk): o_vectors=INIT_VEC; o_load=0; o_pending=0; o_frame_err=0; FSM=IDLE; bit count=0; sync flops preset (ss_n=1, sclk=0, mosi=0); vblank history=1, so no false edge.
- Synchronisers:
  - ss_n, sclk and mosi each pass through SYNC_STAGES flops.
  - Edges are detected from the last two sync stages.
  - Supported sclk is at most clk/4, with each phase at least 2 clk.
- FSM:
  - IDLE: wait for ss_n falling edge, then clear count and go to SHIFT.
  - SHIFT: on each sclk rising edge, shift mosi into shreg LSB and increment count (width clog2(FRAME_BITS)+1).
    - A sclk rise when count==FRAME_BITS goes to OVERRUN.
    - An ss_n rising edge goes to CHECK.
  - OVERRUN: ignore sclk; on ss_n rising edge, pulse o_frame_err and go to IDLE.
  - CHECK (1 cycle):
    - If count==FRAME_BITS: pend <= shreg, o_pending <= 1.
    - Otherwise, including count==0: pulse o_frame_err and leave pend untouched.
    - Always go to IDLE.
- sclk edges while ss_n is high (IDLE) are ignored.
- Commit:
  - On a cycle where i_vblank goes 0->1 and o_pending=1: o_vectors <= pend, o_load=1 for that cycle, o_pending <= 0.
  - A vblank edge with o_pending=0 does nothing.
- Simultaneous vblank edge and CHECK success:
  - The commit uses the pend contents from before the CHECK write.
  - The new frame then becomes pending, so o_pending stays 1.
  - The newest frame always wins pend; earlier uncommitted frames are silently replaced.
- Latency:
  - ss_n rising at the pin to o_pending=1 is SYNC_STAGES+2 clk.
  - vblank edge to o_load/o_vectors update is 1 clk (registered).
- Reset mid-frame: partial shreg is discarded and pend is cleared. After release, a frame already in progress is not captured, because the FSM needs a fresh ss_n fall.
- o_vectors is stable except in o_load cycles.

Optional Feature:
- Macro: VEC_SPI_RX_ERRCNT_EN.
- Enabled:
  - Adds output o_err_count [7:0], reset 0, incremented on every o_frame_err pulse and saturating at 255.
  - Adds input i_err_clr; when 1, the counter is cleared, and the clear has priority over a same-cycle increment.
- Disabled: these ports and the logic do not exist; o_frame_err still pulses.

Test Plan:
- Good frame, then commit: reset, send 96 bits 0x0123_4567_89AB_CDEF_0011_2233 at sclk=clk/8 with i_vblank=0 -> o_pending=1 and o_vectors=0. Raise i_vblank -> next cycle o_vectors=0x0123...2233, o_load pulses 1 cycle, o_pending=0.
- Short frame: send 95 bits -> o_frame_err pulses once, o_pending stays 0; a vblank edge gives no o_load and o_vectors is unchanged.
- Overrun: send 97 bits -> OVERRUN, one o_frame_err at ss_n rise, pend unchanged; then a valid frame A commits normally.
- Back-to-back frames: frames A then B before vblank -> the commit loads B. Time B's CHECK to coincide with the vblank edge after A pending -> A commits, B remains pending, and the next vblank loads B.
- Reset mid-frame: assert reset after 40 bits, release, continue clocking 56 bits and raise ss_n -> no o_pending, one o_frame_err at most (no err if FSM still IDLE: expect 0 err, since no fresh ss_n fall), o_vectors=INIT_VEC.
- With VEC_SPI_RX_ERRCNT_EN: send 300 short frames -> o_err_count=255. Pulse i_err_clr coincident with an error -> count=0.
